// File: rtl/serial_compare_scheduler_pkg.sv
// Shared types for the serial compare scheduler: FSM encodings and result mapping.
package serial_cmp_pkg;

  localparam int unsigned DEF_N_REQ = 4;
  localparam int unsigned DEF_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sched_state_e;

  // One-hot comparator state, bit order {less, eq, greater}
  typedef enum logic [2:0] {
    CMP_LESS    = 3'b100,
    CMP_EQUAL   = 3'b010,
    CMP_GREATER = 3'b001
  } cmp_state_e;

  typedef struct packed {
    logic less;
    logic eq;
    logic greater;
  } cmp_result_t;

  // Map comparator state onto the three result ports
  function automatic cmp_result_t cmp_to_result(input cmp_state_e s);
    cmp_result_t r;
    r.less    = s[2];
    r.eq      = s[1];
    r.greater = s[0];
    return r;
  endfunction

endpackage

// File: rtl/serial_compare_scheduler_if.sv
// Request/result bus of the serial compare scheduler.
interface serial_compare_scheduler_if
  import serial_cmp_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned W     = DEF_W
) ();

  localparam int unsigned IW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic               res_valid;
  logic               res_ready;
  logic [IW-1:0]      res_id;
  logic               res_a_less_b;
  logic               res_a_eq_b;
  logic               res_a_greater_b;

  // Requesters and result consumer
  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_id, res_a_less_b, res_a_eq_b, res_a_greater_b
  );

  // Scheduler
  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_id, res_a_less_b, res_a_eq_b, res_a_greater_b
  );

endinterface

// File: rtl/serial_compare_scheduler_cmp.sv
// MSB-first serial magnitude comparator: first differing bit decides, then absorbs.
module msb_first_compare_fsm
  import serial_cmp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       a,
  input  logic       b,
  output cmp_state_e state
);

  cmp_state_e state_q, state_d;

  // Comparator state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= CMP_EQUAL;
    else      state_q <= state_d;
  end

  // Leave EQUAL on the first differing bit; LESS/GREATER hold until clear
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = CMP_EQUAL;
    end else if (en && (state_q == CMP_EQUAL)) begin
      if (!a && b)      state_d = CMP_LESS;
      else if (a && !b) state_d = CMP_GREATER;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/serial_compare_scheduler.sv
// Round-robin scheduler sharing one serial comparator among N_REQ requesters.
module serial_compare_scheduler
  import serial_cmp_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned W     = DEF_W
) (
  input logic                       clk,
  input logic                       rst,
  serial_compare_scheduler_if.slave bus
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  sched_state_e   state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [IW-1:0]  id_q, id_d;
  logic [IW-1:0]  rr_q, rr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [N_REQ-1:0] grant_c;
  logic [IW-1:0]    gnt_idx_c;
  logic [IW-1:0]    scan_idx_c;
  logic [W-1:0]     a_sel_c;
  logic [W-1:0]     b_sel_c;
  logic [IW-1:0]    ptr_next_c;
  logic             cmp_clr;
  logic             cmp_en;
  cmp_state_e       cmp_state;
  cmp_result_t      res_c;

  // Round-robin search starting at rr_q, wrapping at N_REQ-1
  always_comb begin
    logic found;
    found      = 1'b0;
    grant_c    = '0;
    gnt_idx_c  = '0;
    scan_idx_c = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx_c = IW'((32'(rr_q) + k) % N_REQ);
      if (!found && bus.req_valid[scan_idx_c]) begin
        found               = 1'b1;
        grant_c[scan_idx_c] = 1'b1;
        gnt_idx_c           = scan_idx_c;
      end
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    a_sel_c = '0;
    b_sel_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_c[i]) begin
        a_sel_c = a_sel_c | bus.req_a[i*W +: W];
        b_sel_c = b_sel_c | bus.req_b[i*W +: W];
      end
    end
  end

  assign ptr_next_c = (id_q == IW'(N_REQ - 1)) ? '0 : id_q + IW'(1);

  // Scheduler state register and operand shift registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: accept, shift MSB-first until decided, then hand off the result
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    cmp_clr = 1'b0;
    cmp_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|grant_c) begin
          a_d     = a_sel_c;
          b_d     = b_sel_c;
          id_d    = gnt_idx_c;
          cnt_d   = CW'(W - 1);
          cmp_clr = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        cmp_en = 1'b1;
        if ((a_q[W-1] != b_q[W-1]) || (cnt_q == '0)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          a_d   = a_q << 1;
          b_d   = b_q << 1;
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          rr_d    = ptr_next_c;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  msb_first_compare_fsm u_cmp (
    .clk   (clk),
    .rst   (rst),
    .clr   (cmp_clr),
    .en    (cmp_en),
    .a     (a_q[W-1]),
    .b     (b_q[W-1]),
    .state (cmp_state)
  );

  // Outputs decoded from registered state only; grant is live only in IDLE
  assign res_c               = cmp_to_result(cmp_state);
  assign bus.req_ready       = (state_q == ST_IDLE) ? grant_c : '0;
  assign bus.res_valid       = (state_q == ST_DONE);
  assign bus.res_id          = id_q;
  assign bus.res_a_less_b    = bus.res_valid & res_c.less;
  assign bus.res_a_eq_b      = bus.res_valid & res_c.eq;
  assign bus.res_a_greater_b = bus.res_valid & res_c.greater;

endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Directed + randomized bench for serial_compare_scheduler (W=8 and W=1 instances).
module tb_serial_compare_scheduler;
  import serial_cmp_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_compare_scheduler_if #(.N_REQ(N), .W(W)) bus  ();
  serial_compare_scheduler_if #(.N_REQ(N), .W(1)) bus1 ();

  serial_compare_scheduler #(.N_REQ(N), .W(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  serial_compare_scheduler #(.N_REQ(N), .W(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int ptr_m    = 0;
  int ptr1_m   = 0;
  logic [7:0] op_a [N];
  logic [7:0] op_b [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: first valid index scanning upward from the pointer, wrapping
  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Reference: latency = MSB-relative position of first differing bit + 1, else w
  function automatic int lat_of(input logic [7:0] a, input logic [7:0] b, input int w);
    for (int j = 0; j < w; j++) begin
      if (a[w-1-j] != b[w-1-j]) return j + 1;
    end
    return w;
  endfunction

  function automatic logic [2:0] res_of(input logic [7:0] a, input logic [7:0] b);
    return {a < b, a == b, a > b};
  endfunction

  function automatic logic [2:0] res_now();
    return {bus.res_a_less_b, bus.res_a_eq_b, bus.res_a_greater_b};
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = op_a[i];
      bus.req_b[i*W +: W] = op_b[i];
    end
  endtask

  // One full transaction on the W=8 instance; called and returns at a negedge in IDLE
  task automatic serve(input logic [N-1:0] mask, input int stall);
    int g;
    int c;
    drive_ops();
    bus.req_valid = mask;
    g = rr_pick(mask, ptr_m);
    #1;
    chk("grant", 32'(bus.req_ready), 32'(1 << g));
    @(posedge clk);
    @(negedge clk);
    chk("busy_ready", 32'(bus.req_ready), 32'd0);
    c = 0;
    while (!bus.res_valid && c <= int'(W) + 2) begin
      @(negedge clk);
      c++;
    end
    chk("latency", 32'(c), 32'(lat_of(op_a[g], op_b[g], W)));
    chk("res_id", 32'(bus.res_id), 32'(g));
    chk("result", 32'(res_now()), 32'(res_of(op_a[g], op_b[g])));
    bus.res_ready = (stall == 0);
    for (int s = 1; s <= stall; s++) begin
      @(negedge clk);
      bus.res_ready = (s == stall);
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_id", 32'(bus.res_id), 32'(g));
      chk("hold_result", 32'(res_now()), 32'(res_of(op_a[g], op_b[g])));
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    chk("no_dup", 32'(bus.res_valid), 32'd0);
    ptr_m = (g + 1) % N;
    bus.req_valid = '0;
  endtask

  // One transaction on the W=1 instance
  task automatic serve1(input logic a, input logic b, input int id);
    int c;
    bus1.req_a = '0;
    bus1.req_b = '0;
    bus1.req_a[id] = a;
    bus1.req_b[id] = b;
    bus1.req_valid = 4'(1 << id);
    #1;
    chk("w1_grant", 32'(bus1.req_ready), 32'(1 << rr_pick(bus1.req_valid, ptr1_m)));
    @(posedge clk);
    @(negedge clk);
    bus1.req_valid = '0;
    c = 0;
    while (!bus1.res_valid && c <= 3) begin
      @(negedge clk);
      c++;
    end
    chk("w1_latency", 32'(c), 32'd1);
    chk("w1_result", 32'({bus1.res_a_less_b, bus1.res_a_eq_b, bus1.res_a_greater_b}),
        32'(res_of(8'(a), 8'(b))));
    @(negedge clk);
    chk("w1_no_dup", 32'(bus1.res_valid), 32'd0);
    ptr1_m = (id + 1) % N;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst            = 1'b0;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.res_ready  = 1'b1;
    bus1.req_valid = '0;
    bus1.req_a     = '0;
    bus1.req_b     = '0;
    bus1.res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    // Reset state
    #1;
    bus.req_valid = 4'b1010;
    #1;
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_id", 32'(bus.res_id), 32'd0);
    chk("rst_result", 32'(res_now()), 32'd0);
    chk("rst_grant", 32'(bus.req_ready), 32'b0010);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // W=1 instance: eq, less, greater, eq
    serve1(1'b0, 1'b0, 0);
    serve1(1'b0, 1'b1, 1);
    serve1(1'b1, 1'b0, 2);
    serve1(1'b1, 1'b1, 3);

    // Single request on requester 2, equal operands
    op_a[2] = 8'h5A; op_b[2] = 8'h5A;
    serve(4'b0100, 0);

    // Early termination: MSB decides, then LSB decides
    op_a[0] = 8'h80; op_b[0] = 8'h7F;
    serve(4'b0001, 0);
    op_a[1] = 8'h12; op_b[1] = 8'h13;
    serve(4'b0010, 0);

    // Backpressure with all other requesters waiting
    op_a[3] = 8'h40; op_b[3] = 8'h41;
    serve(4'b1111, 5);

    // Asynchronous reset mid-SHIFT after 3 bits
    op_a[1] = 8'hC3; op_b[1] = 8'hC3;
    drive_ops();
    bus.req_valid = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.res_valid), 32'd0);
    chk("arst_result", 32'(res_now()), 32'd0);
    chk("arst_id", 32'(bus.res_id), 32'd0);
    bus.req_valid = 4'b1111;
    #1;
    chk("arst_grant", 32'(bus.req_ready), 32'b0001);
    bus.req_valid = '0;
    ptr_m  = 0;
    ptr1_m = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_no_replay", 32'(bus.res_valid), 32'd0);
    op_a[3] = 8'h01; op_b[3] = 8'h00;
    serve(4'b1000, 0);

    // Asynchronous reset while holding a result in DONE
    op_a[2] = 8'h80; op_b[2] = 8'h00;
    drive_ops();
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    chk("done_valid", 32'(bus.res_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("drst_valid", 32'(bus.res_valid), 32'd0);
    chk("drst_result", 32'(res_now()), 32'd0);
    ptr_m = 0;
    @(negedge clk);
    rst = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("drst_no_replay", 32'(bus.res_valid), 32'd0);

    // Round-robin with all requests held: order 0,1,2,3,0
    op_a[0] = 8'h10; op_b[0] = 8'h20;
    op_a[1] = 8'hF0; op_b[1] = 8'h0F;
    op_a[2] = 8'h33; op_b[2] = 8'h33;
    op_a[3] = 8'hAA; op_b[3] = 8'hAB;
    for (int r = 0; r < 5; r++) begin
      g = rr_pick(4'b1111, ptr_m);
      chk("rr_order", 32'(g), 32'(r % N));
      serve(4'b1111, 0);
    end

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        op_a[i] = 8'($urandom);
        op_b[i] = ($urandom_range(0, 3) == 0) ? op_a[i] : 8'($urandom);
      end
      serve(4'($urandom_range(1, 15)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_compare_scheduler.md
# serial_compare_scheduler

Shares one MSB-first serial magnitude comparator between `N_REQ` requesters. Each requester offers a pair of `W`-bit operands. A round-robin arbiter grants one pair at a time. The block shifts the pair into the comparator one bit per cycle, most significant bit first, and stops early once the result is decided. The one-hot result is returned with the requester ID over a valid/ready handshake.

## Interface
- `N_REQ`, default 4: number of requesters, ≥ 2.
- `W`, default 8: operand width, ≥ 1.
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset (asserted when 0).
- `req_valid`  in  N_REQ: requester i offers an operand pair.
- `req_ready`  out  N_REQ: one-hot grant; pair i is accepted on a clock edge where `req_valid[i] & req_ready[i]`.
- `req_a`  in  N_REQ*W: operand A of requester i in bits `[i*W +: W]`.
- `req_b`  in  N_REQ*W: operand B, same packing as `req_a`.
- `res_valid`  out  1: result available.
- `res_ready`  in  1: consumer accepts the result.
- `res_id`  out  $clog2(N_REQ): index of the granted requester.
- `res_a_less_b`, `res_a_eq_b`, `res_a_greater_b`  out  1 each: one-hot result; all 0 while `res_valid`=0.

## Operation
- FSM has three states.
  - **IDLE**: `req_ready` is the round-robin grant over `req_valid`. The search starts at pointer `rr_ptr` and wraps at `N_REQ-1`→0. `req_ready` is all-zero when no request is present.
    - On acceptance: latch A, B and the ID; clear the comparator to EQUAL; load bit counter = `W-1`; go to SHIFT.
  - **SHIFT**: `req_ready`=0. Each cycle, apply bit `cnt` of A and B (MSB first) to the comparator.
    - If the bits differ, or `cnt`==0, go to DONE.
    - Otherwise decrement `cnt`.
  - **DONE**: `res_valid`=1 and the result outputs are driven from the registered comparator state.
    - On `res_valid & res_ready`: `rr_ptr` ← granted ID+1 (mod `N_REQ`); go to IDLE.
- Comparator sub-FSM states: EQUAL (reset/clear value), LESS, GREATER.
  - EQUAL→LESS on a=0, b=1.
  - EQUAL→GREATER on a=1, b=0.
  - LESS and GREATER are absorbing until the next clear.
- Requesters hold `req_a`/`req_b` stable while `req_valid` is high and not yet accepted.
  - Only the latched copy is used after acceptance; inputs may change from the next cycle.
  - Deasserting `req_valid` before grant is legal; that request is simply not served.
- Reset values, asserted asynchronously:
  - FSM = IDLE, `rr_ptr` = 0, comparator = EQUAL, `cnt` = 0.
  - `res_valid` = 0, result outputs = 0, `res_id` = 0.
  - After reset release, `req_ready` follows the IDLE grant rule.
- Reset mid-SHIFT or mid-DONE aborts the operation. No result is produced and nothing is replayed.

## Timing
- `req_ready` in IDLE is combinational from `req_valid` and `rr_ptr`. All other outputs are registered.
- Call the acceptance edge E0. If the first differing bit is at MSB-relative position j (0 = MSB), `res_valid` rises after edge E0+j+1.
  - Equal operands take W cycles.
  - MSB mismatch takes 1 cycle.
- With `res_ready` held high, DONE lasts exactly 1 cycle. The next acceptance occurs at the edge after the return to IDLE.
  - Result-to-result interval is therefore latency+2 cycles.
- With `res_ready` low, DONE holds. `res_id` and the result outputs stay stable, and no new request is granted.
- W=1: SHIFT lasts exactly one cycle regardless of the data.
- Round-robin fairness: a continuously asserted request is granted within `N_REQ` grants.

## Structure
- Package `serial_cmp_pkg` contains:
  - the scheduler state enum (IDLE/SHIFT/DONE);
  - the comparator state enum, one-hot 3 bits encoded as {less, eq, greater}: LESS=100, EQUAL=010, GREATER=001;
  - the mapping of that encoding to the three result ports.
- Sub-module `msb_first_compare_fsm` (ports `clk`, `rst`, `clr`, `en`, `a`, `b`, state out) holds the comparator FSM. The scheduler instantiates it once.
- Round-robin grant logic stays inline in the top module.

## Test plan
- Reset and single request, N_REQ=4, W=8:
  - Stimulus: req 2 offers A=0x5A, B=0x5A; `res_ready`=1.
  - Required response: `req_ready`=0100 in the acceptance cycle; `res_valid` exactly 8 cycles after acceptance, with `res_id`=2, eq=1 and less/greater=0.
- Early termination:
  - Stimulus: A=0x80, B=0x7F.
  - Required response: greater=1 after 1 cycle.
  - Stimulus: A=0x12, B=0x13.
  - Required response: less=1 after 8 cycles.
- Round-robin: all four requests held valid continuously.
  - Required response: grant order 0,1,2,3,0 with `rr_ptr` starting at 0; no requester starved.
- Backpressure:
  - Stimulus: hold `res_ready`=0 for 5 cycles in DONE.
  - Required response: outputs stable and `req_ready`=0 for all 5 cycles; one result delivered when `res_ready` rises, with no duplicate.
- Asynchronous reset mid-SHIFT:
  - Stimulus: drive `rst`=0 after 3 bits of a compare.
  - Required response: `res_valid` and all result outputs go to 0 immediately; FSM returns to IDLE with `rr_ptr`=0; a new request after release completes normally.
- W=1 instance:
  - Stimulus: the four pairs (0,0), (0,1), (1,0), (1,1).
  - Required response: eq, less, greater, eq, each with latency 1.
